// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle for the UART TX arbiter: three message sources on one
// side, the UART TX FIFO write port and the busy flag on the other.
interface uart_tx_arbiter_if #(
  parameter int MSG_W = 72
);
  // source 0: error events
  logic             err_valid;
  logic [MSG_W-1:0] err_msg;
  logic             err_ack;
  // source 1: command responses
  logic             resp_valid;
  logic [MSG_W-1:0] resp_msg;
  logic             resp_ack;
  // source 2: reports
  logic             rpt_valid;
  logic [MSG_W-1:0] rpt_msg;
  logic             rpt_ack;
  // UART TX FIFO write port
  logic             uart_out_full;
  logic             uart_out_req;
  logic [MSG_W-1:0] uart_out_msg;
  // arbiter status
  logic             busy;

  // the side that owns the sources and the FIFO
  modport master (
    output err_valid, err_msg, resp_valid, resp_msg, rpt_valid, rpt_msg,
    output uart_out_full,
    input  err_ack, resp_ack, rpt_ack, uart_out_req, uart_out_msg, busy
  );

  // the arbiter itself
  modport slave (
    input  err_valid, err_msg, resp_valid, resp_msg, rpt_valid, rpt_msg,
    input  uart_out_full,
    output err_ack, resp_ack, rpt_ack, uart_out_req, uart_out_msg, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Three-source arbiter feeding one UART TX FIFO. Source 0 (errors) has
// absolute priority, sources 1/2 share round-robin, and a starvation guard
// forces a 1/2 grant after a run of source-0 grants. One message is latched
// per grant and written to the FIFO from a hold register.
module uart_tx_arbiter #(
  parameter int MSG_W = 72,
  parameter int N_SRC = 3   // the grant logic below is written for exactly 3
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_arbiter_if.slave bus
);

  localparam logic [1:0] SRC_ERR  = 2'd0;
  localparam logic [1:0] SRC_RESP = 2'd1;
  localparam logic [1:0] SRC_RPT  = 2'd2;
  // source-0 grants tolerated back to back while 1/2 are waiting
  localparam logic [2:0] STARVE_MAX = 3'd4;

  typedef enum logic {IDLE, SEND} state_t;

  typedef struct packed {
    logic       hit;  // some source wins this cycle
    logic [1:0] src;  // which one
  } grant_t;

  state_t                       state;
  logic [N_SRC-1:0]             ack_q;
  logic [MSG_W-1:0]             hold;
  logic                         last_grant;  // 0: source 1 last, 1: source 2 last
  logic [2:0]                   starve_cnt;
  logic                         out_req_q;
  logic [MSG_W-1:0]             out_msg_q;

  logic [N_SRC-1:0]             vld;
  logic [N_SRC-1:0][MSG_W-1:0]  msgs;
  logic [N_SRC-1:0]             elig;
  logic                         any_lo;
  logic [1:0]                   rr_src;
  grant_t                       gnt;

  // gather the per-source inputs into indexable arrays
  always_comb begin
    vld     = {bus.rpt_valid, bus.resp_valid, bus.err_valid};
    msgs[0] = bus.err_msg;
    msgs[1] = bus.resp_msg;
    msgs[2] = bus.rpt_msg;
  end

  // winner selection: starvation guard, then source 0, then round-robin 1/2
  always_comb begin
    // a source whose ack is on the wire this cycle still shows its old
    // message, so it is never eligible in the same cycle
    elig   = vld & ~ack_q;
    any_lo = elig[1] | elig[2];
    if (elig[1] && elig[2])
      rr_src = last_grant ? SRC_RESP : SRC_RPT;
    else
      rr_src = elig[1] ? SRC_RESP : SRC_RPT;
    gnt.hit = |elig;
    gnt.src = SRC_ERR;
    if (any_lo && starve_cnt >= STARVE_MAX)
      gnt.src = rr_src;
    else if (elig[0])
      gnt.src = SRC_ERR;
    else if (any_lo)
      gnt.src = rr_src;
  end

  // control FSM: grant and latch in IDLE, drain the hold register in SEND
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ack_q      <= '0;
      hold       <= '0;
      last_grant <= 1'b1;  // source 1 takes the first 1/2 tie
      starve_cnt <= '0;
      out_req_q  <= 1'b0;
      out_msg_q  <= '0;
    end else begin
      ack_q     <= '0;
      out_req_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!any_lo)
            starve_cnt <= '0;
          else if (gnt.hit)
            starve_cnt <= (gnt.src == SRC_ERR) ? starve_cnt + 3'd1 : '0;
          if (gnt.hit) begin
            hold             <= msgs[gnt.src];
            ack_q[gnt.src]   <= 1'b1;
            state            <= SEND;
            if (gnt.src != SRC_ERR)
              last_grant <= (gnt.src == SRC_RPT);
          end
        end
        SEND: begin
          // FIFO full: keep the message, try again next cycle
          if (!bus.uart_out_full) begin
            out_req_q <= 1'b1;
            out_msg_q <= hold;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // registered outputs to the sources and the FIFO
  assign bus.err_ack      = ack_q[0];
  assign bus.resp_ack     = ack_q[1];
  assign bus.rpt_ack      = ack_q[2];
  assign bus.uart_out_req = out_req_q;
  assign bus.uart_out_msg = out_msg_q;
  assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter. Drivers feed per-source message
// queues; a negedge monitor predicts each grant from the arbitration rules,
// queues the granted message and matches it against the FIFO writes.
module tb_uart_tx_arbiter;
  localparam int MSG_W = 72;
  typedef logic [MSG_W-1:0] msg_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.MSG_W(MSG_W)) bus();
  uart_tx_arbiter #(.MSG_W(MSG_W), .N_SRC(3)) dut (.clk(clk), .reset(reset), .bus(bus));

  int   n_cmp = 0;
  int   n_err = 0;
  msg_t src_q0[$], src_q1[$], src_q2[$];
  msg_t out_q[$];
  bit   acked[3];
  bit   gap_en = 1'b1;
  int   seq = 0;

  // reference model state
  bit         m_pend = 1'b0;
  bit         m_last = 1'b1;
  int         m_cnt = 0;
  msg_t       exp_last = '0;
  logic [2:0] p_v = '0;
  logic       p_full = 1'b0;
  logic       p_rst = 1'b1;

  task automatic chk(input string name, input msg_t act, input msg_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got event expected none at %0t", name, $time);
  endtask

  function automatic int qsize(int s);
    case (s)
      0: return src_q0.size();
      1: return src_q1.size();
      default: return src_q2.size();
    endcase
  endfunction

  function automatic msg_t qhead(int s);
    case (s)
      0: return src_q0[0];
      1: return src_q1[0];
      default: return src_q2[0];
    endcase
  endfunction

  task automatic qpop(int s);
    case (s)
      0: void'(src_q0.pop_front());
      1: void'(src_q1.pop_front());
      default: void'(src_q2.pop_front());
    endcase
  endtask

  task automatic push(int s, logic [7:0] hdr);
    msg_t m;
    seq++;
    m = {8'(s), 24'(seq), 32'($urandom), hdr};
    case (s)
      0: src_q0.push_back(m);
      1: src_q1.push_back(m);
      default: src_q2.push_back(m);
    endcase
  endtask

  // Arbitration rules: errors first, except that after four error grants
  // in a row with 1/2 waiting, 1/2 get one turn; 1/2 alternate on ties.
  function automatic int choose(logic [2:0] v, bit last, int cnt);
    int rr;
    bit lo;
    lo = v[1] | v[2];
    if (v[1] && v[2]) rr = last ? 1 : 2;
    else rr = v[1] ? 1 : 2;
    if (lo && cnt >= 4) return rr;
    if (v[0]) return 0;
    return rr;
  endfunction

  // source drivers: present the head message, hold until acked
  initial begin
    bus.err_valid = 1'b0; bus.resp_valid = 1'b0; bus.rpt_valid = 1'b0;
    bus.err_msg = '0; bus.resp_msg = '0; bus.rpt_msg = '0;
    forever begin
      @(posedge clk); #1;
      for (int s = 0; s < 3; s++) begin
        logic v;
        v = (s == 0) ? bus.err_valid : (s == 1) ? bus.resp_valid : bus.rpt_valid;
        if (acked[s]) begin
          acked[s] = 1'b0;
          if (qsize(s) > 0) qpop(s);
          v = 1'b0;
        end
        if (!v && qsize(s) > 0 && (!gap_en || $urandom_range(0, 2) != 0)) begin
          v = 1'b1;
          case (s)
            0: bus.err_msg = qhead(0);
            1: bus.resp_msg = qhead(1);
            default: bus.rpt_msg = qhead(2);
          endcase
        end
        case (s)
          0: bus.err_valid = v;
          1: bus.resp_valid = v;
          default: bus.rpt_valid = v;
        endcase
      end
    end
  end

  // monitor + scoreboard
  initial begin
    logic [2:0] a;
    logic       req, bz;
    msg_t       om;
    int         e, s;
    forever begin
      @(negedge clk);
      a   = {bus.rpt_ack, bus.resp_ack, bus.err_ack};
      req = bus.uart_out_req;
      om  = bus.uart_out_msg;
      bz  = bus.busy;
      if (p_rst) begin
        chk("rst_ack", 72'(a), '0);
        chk("rst_req", 72'(req), '0);
        chk("rst_busy", 72'(bz), '0);
        chk("rst_msg", om, exp_last);
        m_pend = 1'b0;
      end else begin
        chk("ack_timing", 72'(|a), 72'(!m_pend && (p_v != 3'b000)));
        chk("ack_onehot", 72'($onehot0(a)), 72'(1));
        if (!m_pend) begin
          if (p_v != 3'b000) begin
            e = choose(p_v, m_last, m_cnt);
            if (|a) chk("ack_winner", 72'(a), 72'(3'b001 << e));
            if (e == 0) m_cnt = (p_v[1] | p_v[2]) ? m_cnt + 1 : 0;
            else begin
              m_cnt  = 0;
              m_last = (e == 2);
            end
          end else m_cnt = 0;
        end
        if (|a) begin
          s = a[0] ? 0 : a[1] ? 1 : 2;
          if (qsize(s) == 0) fail("ack_spurious");
          else begin
            out_q.push_back(qhead(s));
            acked[s] = 1'b1;
          end
        end
        chk("req_timing", 72'(req), 72'(m_pend && !p_full));
        if (req) begin
          if (out_q.size() == 0) fail("req_extra");
          else exp_last = out_q.pop_front();
        end
        chk("out_msg", om, exp_last);
        m_pend = (m_pend && !req) || (|a);
        chk("busy", 72'(bz), 72'(m_pend));
      end
      p_v    = {bus.rpt_valid, bus.resp_valid, bus.err_valid};
      p_full = bus.uart_out_full;
      p_rst  = reset;
      if (reset) begin
        out_q.delete();
        m_last   = 1'b1;
        m_cnt    = 0;
        exp_last = '0;
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drain(input string name, int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (qsize(0) == 0 && qsize(1) == 0 && qsize(2) == 0 && out_q.size() == 0 && !m_pend)
        break;
    end
    if (k == budget) fail(name);
    cyc(1);
  endtask

  initial begin
    bus.uart_out_full = 1'b0;
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(2);

    // simultaneous requests from all three sources
    gap_en = 1'b0;
    push(0, 8'h10); push(1, 8'h01); push(2, 8'h20);
    drain("drain_priority", 100);

    // single response message
    push(1, 8'h01);
    drain("drain_single", 50);

    // two sources held valid: strict alternation
    for (int i = 0; i < 4; i++) begin push(1, 8'h01); push(2, 8'h21); end
    drain("drain_rr", 200);

    // error source continuously valid next to a response
    for (int i = 0; i < 8; i++) push(0, 8'h11);
    push(1, 8'h02); push(1, 8'h03);
    drain("drain_starve", 300);

    // FIFO full across a long SEND
    bus.uart_out_full = 1'b1;
    push(1, 8'h01); push(2, 8'h22);
    cyc(50);
    bus.uart_out_full = 1'b0;
    drain("drain_backpressure", 100);

    // reset while a message is held
    bus.uart_out_full = 1'b1;
    push(2, 8'h23);
    cyc(6);
    reset = 1'b1;
    cyc(2);
    bus.uart_out_full = 1'b0;
    reset = 1'b0;
    cyc(1);
    push(1, 8'h01);
    drain("drain_after_reset", 100);

    // random traffic and random backpressure
    gap_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      for (int s = 0; s < 3; s++)
        if (qsize(s) < 4 && $urandom_range(0, 5) == 0) push(s, 8'($urandom));
      bus.uart_out_full = ($urandom_range(0, 3) == 0);
      cyc(1);
    end
    bus.uart_out_full = 1'b0;
    drain("drain_random", 2000);

    chk("end_out_q", 72'(out_q.size()), '0);
    chk("end_src_q", 72'(qsize(0) + qsize(1) + qsize(2)), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // absolute time limit
  initial begin
    #900000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter MSG_W, 72, width of one UART message (8-bit header in [7:0], 64-bit payload in [71:8]).
REQ-002 Parameter N_SRC, 3, number of requesters; fixed at 3 for this revision.
REQ-003 clk  input  1  system clock; one clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 err_valid  input  1  source 0 (error events: overrun, FIFO full) has a message.
REQ-006 err_msg  input  MSG_W  source 0 message; stable while err_valid=1.
REQ-007 err_ack  output  1  one-cycle pulse: source 0 message accepted.
REQ-008 resp_valid / resp_msg / resp_ack  in / in / out  1 / MSG_W / 1  source 1 (command ack/err responses), same handshake as source 0.
REQ-009 rpt_valid / rpt_msg / rpt_ack  in / in / out  1 / MSG_W / 1  source 2 (received-wrong/replace-done reports), same handshake as source 0.
REQ-010 uart_out_full  input  1  UART TX FIFO cannot accept a write this cycle.
REQ-011 uart_out_req  output  1  one-cycle write strobe to UART TX FIFO.
REQ-012 uart_out_msg  output  MSG_W  message written; valid when uart_out_req=1.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 State machine SHALL have two states, IDLE and SEND, encoded in a registered state variable.
REQ-015 In IDLE with at least one valid asserted, the arbiter SHALL select a winner, latch its msg into a hold register, pulse the winner's ack for exactly one cycle, and enter SEND on the next edge.
REQ-016 Selection SHALL give source 0 absolute priority; between sources 1 and 2, round-robin via a last_grant bit, preferring the source not granted last; last_grant updates only on a source 1/2 grant.
REQ-017 Starvation guard: after 4 consecutive source-0 grants while source 1 or 2 was valid, the next grant SHALL go to the round-robin winner of 1/2; the counter clears on any 1/2 grant or when no 1/2 valid.
REQ-018 A source SHALL not be granted in the cycle immediately after its ack, even if its valid is still high (handshake turnaround).
REQ-019 Acks SHALL be mutually exclusive; at most one ack high per cycle.
REQ-020 In SEND, if uart_out_full=0, uart_out_req SHALL be 1 for one cycle with uart_out_msg = hold register, and state returns to IDLE; if uart_out_full=1, the arbiter SHALL hold in SEND with uart_out_req=0 and hold register unchanged.
REQ-021 uart_out_req and uart_out_msg SHALL be registered outputs; latency from winner's valid (IDLE, FIFO not full) to uart_out_req is 2 cycles; peak throughput one message per 2 cycles.
REQ-022 uart_out_msg SHALL retain its last value when uart_out_req=0.
REQ-023 Valid inputs arriving while in SEND SHALL be ignored until return to IDLE; no acks are issued in SEND.
REQ-024 No message SHALL be dropped, duplicated or reordered within one source.

Reset
REQ-025 While reset=1 at a rising edge: state=IDLE, all acks=0, uart_out_req=0, uart_out_msg=0, hold register=0, last_grant=source 2 (so source 1 wins first tie), starvation counter=0, busy=0.
REQ-026 Reset asserted in SEND SHALL discard the held message without writing it; sources already acked are not re-acked.
REQ-027 First grant SHALL occur no earlier than the first edge after reset deasserts.

Verification
REQ-028 Single: resp_valid=1, resp_msg=0x..._01 header ACK, full=0 -> resp_ack cycle 1, uart_out_req with same msg cycle 2, busy high one cycle.
REQ-029 Priority: err, resp, rpt valid same cycle -> output order err, resp, rpt; each ack exactly once; no ack during SEND.
REQ-030 Round-robin: resp and rpt held valid with 4 messages each -> strict alternation resp, rpt, resp, rpt...
REQ-031 Starvation: err valid continuously, resp valid -> after 4 err writes, 1 resp write, then err resumes.
REQ-032 Backpressure: full=1 for 50 cycles during SEND -> no uart_out_req, no new acks; full=0 -> held msg written once next cycle.
REQ-033 Reset mid-SEND with full=1 -> no write after reset, all outputs 0; subsequent resp message delivered normally; bench scoreboard queues empty at end.
